// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 digest checker.
// golden_word() picks word idx of a 256-bit digest, word 0 being H0 in the top bits.
package sha256_pkg;

  localparam int DIGEST_WORDS = 8;
  localparam int WORD_W       = 32;
  localparam int DIGEST_W     = DIGEST_WORDS * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] golden_word(input logic [DIGEST_W-1:0] g,
                                                    input logic [2:0]          idx);
    return g[(DIGEST_WORDS - 1 - int'(idx)) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with an increment enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_digest_checker.sv
// Compares a streamed 8-word SHA-256 digest against a preloaded golden digest.
// state  | meaning
// IDLE   | wait for a golden load; once armed, start receiving
// RECV   | accept digest words H0..H7, accumulate mismatch
// REPORT | one-cycle result cycle; done/match/counters already updated
module sha256_digest_checker
  import sha256_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                golden_load,
  input  logic [DIGEST_W-1:0] golden,
  input  logic                dig_valid,
  input  logic [WORD_W-1:0]   dig_word,
  output logic                dig_ready,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic [CNT_W-1:0]    errors,
  output logic [CNT_W-1:0]    checks
);

  state_t              state;
  logic                armed;
  logic [2:0]          index;
  logic                mismatch;
  logic [DIGEST_W-1:0] golden_q;

  logic accept;
  logic last_beat;
  logic mismatch_next;

  assign accept        = dig_valid & dig_ready;
  assign last_beat     = accept && (index == 3'd7);
  assign mismatch_next = mismatch | (dig_word != golden_word(golden_q, index));

  // Results are registered on the last-beat edge so they are visible during REPORT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      index     <= '0;
      mismatch  <= 1'b0;
      golden_q  <= '0;
      dig_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (golden_load) begin
            golden_q <= golden;
            armed    <= 1'b1;
          end
          if (armed) begin
            state     <= ST_RECV;
            index     <= '0;
            mismatch  <= 1'b0;
            dig_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_RECV: begin
          if (accept) begin
            mismatch <= mismatch_next;
            index    <= index + 1'b1;
            if (index == 3'd7) begin
              state     <= ST_REPORT;
              dig_ready <= 1'b0;
              done      <= 1'b1;
              match     <= ~mismatch_next;
            end
          end
        end
        ST_REPORT: begin
          armed <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_errors (
    .clk   (clk),
    .reset (reset),
    .inc   (last_beat & mismatch_next),
    .count (errors)
  );

  sat_counter #(.W(CNT_W)) u_checks (
    .clk   (clk),
    .reset (reset),
    .inc   (last_beat),
    .count (checks)
  );

endmodule

// File: tb/tb_sha256_digest_checker.sv
// Scoreboarded bench for sha256_digest_checker: a 32-bit counter instance plus a
// CNT_W=2 instance (held in reset until the saturation scenario) sharing stimulus.
module tb_sha256_digest_checker;

  localparam logic [255:0] G_MAIN =
    256'hd0e8b8f1_4a7c2e93_1f6d08b5_c3a9e742_86b2d05e_5b3104c7_e91f3a6d_75a46271;
  localparam logic [255:0] G_OTHER =
    256'h01234567_89abcdef_fedcba98_76543210_0badf00d_deadbeef_cafebabe_12345678;

  typedef struct packed {
    logic        m;
    logic [31:0] e;
    logic [31:0] c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, rst2_n;
  logic         golden_load;
  logic [255:0] golden;
  logic         dig_valid;
  logic [31:0]  dig_word;
  logic         dig_ready, busy, done, match;
  logic [31:0]  errors, checks;
  logic         dig_ready2, busy2, done2, match2;
  logic [1:0]   errors2, checks2;

  int   cyc = 0;
  int   beats = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   model_err = 0;
  int   model_chk = 0;
  exp_t exp_q[$];

  sha256_digest_checker #(.CNT_W(32)) dut (
    .clk(clk), .reset(rst_n), .golden_load(golden_load), .golden(golden),
    .dig_valid(dig_valid), .dig_word(dig_word), .dig_ready(dig_ready),
    .busy(busy), .done(done), .match(match), .errors(errors), .checks(checks)
  );

  sha256_digest_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(rst2_n), .golden_load(golden_load), .golden(golden),
    .dig_valid(dig_valid), .dig_word(dig_word), .dig_ready(dig_ready2),
    .busy(busy2), .done(done2), .match(match2), .errors(errors2), .checks(checks2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && dig_valid && dig_ready) beats <= beats + 1;

  // Model of the counters: push the expected result of one check.
  task automatic push_expect(input logic m, input int maxv);
    if (!m && model_err < maxv) model_err++;
    if (model_chk < maxv) model_chk++;
    exp_q.push_back('{m: m, e: 32'(model_err), c: 32'(model_chk)});
  endtask

  task automatic load_golden(input logic [255:0] g);
    @(negedge clk);
    golden_load = 1'b1;
    golden      = g;
    @(negedge clk);
    golden_load = 1'b0;
  endtask

  // Sends words start..start+n-1 of g; returns at the negedge after the last accepting edge.
  task automatic send_digest(input logic [255:0] g, input int start, input int n,
                             input int bad_idx, input logic [31:0] bad_word, input bit gap,
                             output int first_cyc, output int last_cyc, output bit ok);
    ok = 1'b1;
    first_cyc = -1;
    last_cyc = -1;
    for (int i = start; i < start + n; i++) begin
      bit          acc;
      int          waited;
      logic [31:0] w;
      acc = 1'b0;
      waited = 0;
      w = g[(7 - i) * 32 +: 32];
      if (i == bad_idx) w = bad_word;
      while (!acc && waited < 32) begin
        @(negedge clk);
        dig_valid = 1'b1;
        dig_word  = w;
        if (dig_ready === 1'b1) begin
          acc = 1'b1;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end else begin
          waited++;
        end
      end
      if (!acc) ok = 1'b0;
      if (gap && i < start + n - 1) begin
        @(negedge clk);
        dig_valid = 1'b0;
      end
    end
    @(negedge clk);
    dig_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst2_n = 1'b0;
    golden_load = 1'b0; golden = '0; dig_valid = 1'b0; dig_word = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dig_ready, busy, done, match} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {dig_ready, busy, done, match});
    else n_pass++;
    n_checks++;
    if (errors !== 32'd0 || checks !== 32'd0)
      $display("FAIL reset_counters: got errors=%0d checks=%0d want 0/0", errors, checks);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  // Shared tail of each full-check scenario: compare DUT results with the scoreboard.
  task automatic test_check_result(input string name, input bit ok, input int last_cyc);
    exp_t e;
    n_checks++;
    if (!ok || exp_q.size() == 0) begin
      $display("FAIL %s_accept: got ok=%0b queued=%0d want ok=1 queued>0", name, ok, exp_q.size());
      return;
    end else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 1'b1 || (cyc - last_cyc) !== 1)
      $display("FAIL %s_done_latency: got done=%0b latency=%0d want done=1 latency=1", name, done, cyc - last_cyc);
    else n_pass++;
    n_checks++;
    if (match !== e.m) $display("FAIL %s_match: got %0b want %0b", name, match, e.m);
    else n_pass++;
    n_checks++;
    if (errors !== e.e || checks !== e.c)
      $display("FAIL %s_counters: got errors=%0d checks=%0d want %0d/%0d", name, errors, checks, e.e, e.c);
    else n_pass++;
  endtask

  task automatic test_match;
    int f, l, b0; bit ok;
    b0 = beats;
    load_golden(G_MAIN);
    push_expect(1'b1, 32'h7fffffff);
    send_digest(G_MAIN, 0, 8, -1, '0, 1'b0, f, l, ok);
    test_check_result("match", ok, l);
    n_checks++;
    if ((l - f) !== 7 || (beats - b0) !== 8)
      $display("FAIL match_b2b: got span=%0d beats=%0d want 7/8", l - f, beats - b0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || match !== 1'b1)
      $display("FAIL match_hold: got done=%0b match=%0b want 0/1", done, match);
    else n_pass++;
  endtask

  task automatic test_mismatch;
    int f, l; bit ok;
    load_golden(G_MAIN);
    push_expect(1'b0, 32'h7fffffff);
    send_digest(G_MAIN, 0, 8, 5, 32'h5b3104c8, 1'b0, f, l, ok);
    test_check_result("mismatch", ok, l);
  endtask

  task automatic test_toggle;
    int f, l, b0; bit ok;
    b0 = beats;
    load_golden(G_MAIN);
    push_expect(1'b1, 32'h7fffffff);
    send_digest(G_MAIN, 0, 8, -1, '0, 1'b1, f, l, ok);
    test_check_result("toggle", ok, l);
    dig_valid = 1'b1;
    repeat (3) @(negedge clk);
    dig_valid = 1'b0;
    n_checks++;
    if ((l - f + 1) !== 15 || (beats - b0) !== 8)
      $display("FAIL toggle_beats: got cycles=%0d beats=%0d want 15/8", l - f + 1, beats - b0);
    else n_pass++;
  endtask

  task automatic test_load_in_recv;
    int f, l; bit ok, ok2;
    load_golden(G_MAIN);
    push_expect(1'b1, 32'h7fffffff);
    send_digest(G_MAIN, 0, 4, -1, '0, 1'b0, f, l, ok);
    golden_load = 1'b1;
    golden      = G_OTHER;
    n_checks++;
    if (busy !== 1'b1 || dig_ready !== 1'b1)
      $display("FAIL recv_busy: got busy=%0b ready=%0b want 1/1", busy, dig_ready);
    else n_pass++;
    @(negedge clk);
    golden_load = 1'b0;
    send_digest(G_MAIN, 4, 4, -1, '0, 1'b0, f, l, ok2);
    test_check_result("load_in_recv", ok & ok2, l);
  endtask

  task automatic test_overwrite;
    int f, l; bit ok;
    @(negedge clk);
    golden_load = 1'b1;
    golden      = G_OTHER;
    @(negedge clk);
    golden      = G_MAIN;
    @(negedge clk);
    golden_load = 1'b0;
    push_expect(1'b1, 32'h7fffffff);
    send_digest(G_MAIN, 0, 8, -1, '0, 1'b0, f, l, ok);
    test_check_result("overwrite", ok, l);
  endtask

  task automatic test_reset_mid;
    int f, l, b0; bit ok, seen_ready;
    load_golden(G_MAIN);
    send_digest(G_MAIN, 0, 3, -1, '0, 1'b0, f, l, ok);
    n_checks++;
    if (!ok || busy !== 1'b1) $display("FAIL midrst_pre: got ok=%0b busy=%0b want 1/1", ok, busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dig_ready, busy, done, match} !== 4'b0000 || errors !== 32'd0 || checks !== 32'd0)
      $display("FAIL midrst_outputs: got flags=%b errors=%0d checks=%0d want 0000/0/0",
               {dig_ready, busy, done, match}, errors, checks);
    else n_pass++;
    model_err = 0;
    model_chk = 0;
    @(negedge clk);
    rst_n = 1'b1;
    b0 = beats;
    seen_ready = 1'b0;
    dig_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (dig_ready !== 1'b0) seen_ready = 1'b1;
    end
    dig_valid = 1'b0;
    n_checks++;
    if (seen_ready || beats != b0)
      $display("FAIL midrst_needs_load: got ready_seen=%0b beats=%0d want 0/0", seen_ready, beats - b0);
    else n_pass++;
    load_golden(G_MAIN);
    push_expect(1'b1, 32'h7fffffff);
    send_digest(G_MAIN, 0, 8, -1, '0, 1'b0, f, l, ok);
    test_check_result("midrst_full", ok, l);
  endtask

  task automatic test_saturation;
    int f, l; bit ok;
    exp_t e;
    @(negedge clk);
    rst2_n = 1'b1;
    model_err = 0;
    model_chk = 0;
    for (int k = 0; k < 5; k++) begin
      load_golden(G_MAIN);
      push_expect(1'b0, 3);
      send_digest(G_MAIN, 0, 8, 0, 32'h00000000, 1'b0, f, l, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || done2 !== 1'b1 || match2 !== e.m || {30'd0, errors2} !== e.e || {30'd0, checks2} !== e.c)
        $display("FAIL sat_%0d: got ok=%0b done=%0b match=%0b errors=%0d checks=%0d want 1/1/%0b/%0d/%0d",
                 k, ok, done2, match2, errors2, checks2, e.m, e.e, e.c);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_toggle();
    test_load_in_recv();
    test_overwrite();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
